peripheral_sevenseg: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 31 +++
 rtl/sevenseg_glyph_dec.sv | 17 +
 rtl/peripheral_sevenseg.sv | 143 ++++++++++++++
 tb/tb_peripheral_sevenseg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_pkg
// Brief    : Register offsets, CTRL layout and glyph table for the 7-seg driver
// Revision : 1.0  initial release
// ============================================================================
package sevenseg_pkg;

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_DPMASK = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BRIGHT_LSB = 1;
    localparam int CTRL_LZB_BIT    = 4;

    typedef struct packed {
        logic       lzb;
        logic [2:0] bright;
        logic       enable;
    } ctrl_t;

    // Active-high {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] GLYPH_ROM = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage
`default_nettype wire

// File: rtl/sevenseg_glyph_dec.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_glyph_dec
// Brief    : Combinational hex nibble to active-high 7-segment glyph
// Revision : 1.0  initial release
// ============================================================================
module sevenseg_glyph_dec
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb glyph = GLYPH_ROM[nibble];

endmodule
`default_nettype wire

// File: rtl/peripheral_sevenseg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_sevenseg
// Brief    : Memory-mapped multiplexed 7-segment driver with PWM brightness.
//            Define SEVENSEG_LZB_EN to enable leading-zero blanking (CTRL[4]).
// Revision : 1.0  initial release
// ============================================================================
module peripheral_sevenseg
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_W     = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           d_in,
    input  logic                  cs,
    input  logic [4:0]            addr,
    input  logic                  rd,
    input  logic                  wr,
    output logic [31:0]           d_out,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DATA_W-1:0]     r_data;
    logic [NUM_DIGITS-1:0] r_dpmask;
    ctrl_t                 r_ctrl;
    logic [SLOT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]      r_idx;

    logic [31:0] w_rdata;
    logic        w_lit;
    logic        w_blank;
    logic [3:0]  w_nibble;
    logic [6:0]  w_glyph;
    logic        w_unused;

    assign w_unused = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= '0;
            r_dpmask <= '0;
            r_ctrl   <= '0;
        end else if (cs && wr) begin
            case (addr[4:2])
                OFF_DATA:   r_data   <= d_in[DATA_W-1:0];
                OFF_DPMASK: r_dpmask <= d_in[NUM_DIGITS-1:0];
                OFF_CTRL: begin
                    r_ctrl.enable <= d_in[CTRL_EN_BIT];
                    r_ctrl.bright <= d_in[CTRL_BRIGHT_LSB +: 3];
`ifdef SEVENSEG_LZB_EN
                    r_ctrl.lzb    <= d_in[CTRL_LZB_BIT];
`endif
                end
                default: ;
            endcase
        end
    end

    // STATUS masks idx while disabled so the one cycle before the clear lands is hidden.
    always_comb begin
        w_rdata = '0;
        case (addr[4:2])
            OFF_DATA:   w_rdata[DATA_W-1:0]     = r_data;
            OFF_DPMASK: w_rdata[NUM_DIGITS-1:0] = r_dpmask;
            OFF_CTRL:   w_rdata[4:0]            = r_ctrl;
            OFF_STATUS: begin
                w_rdata[IDX_W-1:0] = r_ctrl.enable ? r_idx : '0;
                w_rdata[2]         = w_lit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (cs && rd) begin
            d_out <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !r_ctrl.enable) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // cnt==0 is kept dark so the anode switch never shows the previous digit.
    assign w_lit    = r_ctrl.enable && (r_cnt != '0) && (r_cnt[SLOT_W-1 -: 3] <= r_ctrl.bright);
    assign w_nibble = r_data[4*r_idx +: 4];

    sevenseg_glyph_dec u_glyph_dec (
        .nibble (w_nibble),
        .glyph  (w_glyph)
    );

`ifdef SEVENSEG_LZB_EN
    logic [IDX_W-1:0] w_highest;

    always_comb begin
        w_highest = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_data[4*i +: 4] != 4'd0) w_highest = IDX_W'(i);
        end
    end

    assign w_blank = r_ctrl.lzb && (r_idx > w_highest);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || !w_lit) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            dp_n <= ~r_dpmask[r_idx];
            if (w_blank) begin
                an_n  <= '1;
                seg_n <= 7'h7F;
            end else begin
                an_n  <= ~(NUM_DIGITS'(1) << r_idx);
                seg_n <= ~w_glyph;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_sevenseg.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_sevenseg
// Brief    : Directed + random bench for peripheral_sevenseg (SLOT_W=4)
// Revision : 1.0  initial release
// ============================================================================
module tb_peripheral_sevenseg;

    localparam int SW   = 4;
    localparam int ND   = 4;
    localparam int SLOT = 1 << SW;
`ifdef SEVENSEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d_out;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: shadow registers plus edges elapsed since enable.
    logic [15:0] m_data   = '0;
    logic [3:0]  m_dp     = '0;
    logic        m_en     = 1'b0;
    int          m_bright = 0;
    logic        m_lzb    = 1'b0;
    int          t        = 0;
    logic [31:0] m_dout   = '0;

    peripheral_sevenseg #(.NUM_DIGITS(ND), .SLOT_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .seg_n (seg_n),
        .dp_n  (dp_n),
        .an_n  (an_n)
    );

    always #5 clk = ~clk;

    function automatic int cur_cnt();
        return m_en ? (t % SLOT) : 0;
    endfunction

    function automatic int cur_idx();
        return m_en ? ((t / SLOT) % ND) : 0;
    endfunction

    function automatic logic cur_lit();
        int c;
        c = cur_cnt();
        return m_en && (c != 0) && ((c >> (SW - 3)) <= m_bright);
    endfunction

    // Expected {an_n, seg_n, dp_n} after the coming edge.
    function automatic logic [11:0] exp_pins();
        int idx, hi;
        logic [3:0] nib;
        logic [3:0] an;
        idx = cur_idx();
        if (!cur_lit()) return {4'hF, 7'h7F, 1'b1};
        hi = 0;
        for (int i = 1; i < ND; i++) if (m_data[4*i +: 4] != 4'd0) hi = i;
        if (m_lzb && idx > hi) return {4'hF, 7'h7F, ~m_dp[idx]};
        nib = m_data[4*idx +: 4];
        an  = 4'hF;
        an[idx] = 1'b0;
        return {an, ~GLYPH[nib], ~m_dp[idx]};
    endfunction

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        logic [31:0] v;
        int idx;
        v = '0;
        case (a[4:2])
            3'd0: v[15:0] = m_data;
            3'd1: v[3:0]  = m_dp;
            3'd2: v[4:0]  = {m_lzb, 3'(m_bright), m_en};
            3'd3: begin
                idx  = cur_idx();
                v[1:0] = 2'(idx);
                v[2]   = cur_lit();
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic rdi, input logic wri,
                        input logic [4:0] a, input logic [15:0] d);
        logic [11:0] e;
        logic [31:0] rv;
        reset = r; cs = c; rd = rdi; wr = wri; addr = a; d_in = d;
        e  = exp_pins();
        rv = reg_val(a);
        @(posedge clk);
        #1;
        if (r) begin
            m_data = '0; m_dp = '0; m_en = 1'b0; m_bright = 0; m_lzb = 1'b0;
            t = 0; m_dout = '0;
            e = {4'hF, 7'h7F, 1'b1};
        end else begin
            if (c && rdi) m_dout = rv;
            t = m_en ? t + 1 : 0;
            if (c && wri) begin
                case (a[4:2])
                    3'd0: m_data = d;
                    3'd1: m_dp   = d[3:0];
                    3'd2: begin
                        m_en     = d[0];
                        m_bright = int'(d[3:1]);
                        m_lzb    = LZB & d[4];
                    end
                    default: ;
                endcase
            end
        end
        chk("pins", {20'b0, an_n, seg_n, dp_n}, {20'b0, e});
        chk("d_out", d_out, m_dout);
        reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [4:0] a);
        step(1'b0, 1'b1, 1'b1, 1'b0, a, 16'h0);
    endtask

    initial begin
        logic [31:0] rnd;
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
        chk("rst_an", {28'b0, an_n}, 32'hF);
        chk("rst_seg", {25'b0, seg_n}, 32'h7F);
        rd_reg(5'd0);  chk("rst_data", d_out, 32'h0);
        rd_reg(5'd4);  chk("rst_dpmask", d_out, 32'h0);
        rd_reg(5'd8);  chk("rst_ctrl", d_out, 32'h0);
        rd_reg(5'd12); chk("rst_status", d_out, 32'h0);

        wr_reg(5'd0, 16'h1234);
        wr_reg(5'd8, 16'h000F);
        idle(2);
        chk("dig0_an", {28'b0, an_n}, 32'hE);
        chk("dig0_seg", {25'b0, seg_n}, {25'b0, ~7'h66});
        idle(70);

        wr_reg(5'd8, 16'h0001);
        idle(70);

        wr_reg(5'd0, 16'h00AF);
        wr_reg(5'd4, 16'h0004);
        wr_reg(5'd8, 16'h000F);
        idle(70);

        if (LZB) begin
            wr_reg(5'd0, 16'h0042);
            wr_reg(5'd8, 16'h001F);
            idle(70);
            wr_reg(5'd0, 16'h0000);
            idle(70);
        end

        // Same-edge read and write of DATA must return the old value.
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 16'hBEEF);
        rd_reg(5'd0);
        rd_reg(5'd20);

        wr_reg(5'd8, 16'h000F);
        idle(21);
        wr_reg(5'd8, 16'h0000);
        idle(1);
        chk("off_an", {28'b0, an_n}, 32'hF);
        rd_reg(5'd12);
        chk("off_status", d_out, 32'h0);
        wr_reg(5'd8, 16'h000F);
        idle(2);
        chk("restart_an", {28'b0, an_n}, 32'hE);

        for (int r = 0; r < 6; r++) begin
            rnd = $urandom; wr_reg(5'd0, rnd[15:0]);
            rnd = $urandom; wr_reg(5'd4, rnd[15:0]);
            rnd = $urandom; wr_reg(5'd8, rnd[15:0] | 16'h1);
            for (int k = 0; k < 80; k++) begin
                rnd = $urandom;
                if (rnd[7:5] == 3'd0)
                    rd_reg(rnd[4:0]);
                else if (rnd[12:8] == 5'd0)
                    step(1'b0, 1'b1, rnd[13], 1'b1, rnd[4:0], rnd[31:16]);
                else
                    idle(1);
            end
        end

        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 16'hFFFF);
        rd_reg(5'd0);
        chk("midrst_data", d_out, 32'h0);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
